score_display: RTL

Downstream consumer of the scorekeeper's `score` and `highScore` registers. It converts the selected 32-bit binary value to six BCD digits with a sequential shift-add-3 (double-dabble) engine and drives six active-low seven-segment displays (HEX0 is the least significant digit). A new conversion starts whenever the selected value or the selection changes. Values above 999999 saturate to 999999 and raise a flag.

---
 rtl/score_display_pkg.sv | 28 ++
 rtl/score_display_seg7_decoder.sv | 39 +++
 rtl/score_display.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_display_pkg
// Purpose  : Shared types and constants for the score display block.
//            Holds the converter FSM state encoding, the largest value that
//            fits in six BCD digits, and the seven-segment patterns for a
//            blank digit and for "0".
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package score_display_pkg;

    // Converter FSM state encoding, width stated explicitly
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest value representable in six BCD digits
    localparam int unsigned BCD_MAX = 999999;

    // Active-low {g,f,e,d,c,b,a} segment patterns
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage : score_display_pkg
`default_nettype wire

// File: rtl/score_display_seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decoder
// Purpose  : Combinational BCD to active-low seven-segment decoder.
//            Nibbles 0xA-0xF, and any digit with i_blank set, show nothing.
// Ports    : i_digit [3:0] - BCD digit
//            i_blank       - force the display dark
//            o_seg   [6:0] - active-low segments {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_ZERO;
                4'd1:    o_seg = 7'b1111001;
                4'd2:    o_seg = 7'b0100100;
                4'd3:    o_seg = 7'b0110000;
                4'd4:    o_seg = 7'b0011001;
                4'd5:    o_seg = 7'b0010010;
                4'd6:    o_seg = 7'b0000010;
                4'd7:    o_seg = 7'b1111000;
                4'd8:    o_seg = 7'b0000000;
                4'd9:    o_seg = 7'b0010000;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule : seg7_decoder
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module   : score_display
// Purpose  : Converts the selected score (score or highScore) to six BCD
//            digits with a sequential double-dabble engine and drives six
//            active-low seven-segment displays. A conversion starts whenever
//            the selected value or the selection changes; values above
//            999999 saturate and raise overflow.
// Macro    : SCORE_DISPLAY_LEADING_ZERO_BLANK_EN - blank leading zero digits
//            (HEX0 always shows its digit).
// Ports    : Clock, reset (async, active-high)
//            score, highScore [31:0] - values from the scorekeeper
//            showHigh                - 1 selects highScore
//            busy                    - conversion in flight
//            valid                   - one-cycle pulse on display update
//            overflow                - displayed value was saturated
//            bcd [23:0]              - registered BCD result
//            HEX0..HEX5 [6:0]        - active-low segments, HEX0 = LSD
// Revision : 1.0 - initial release
// ============================================================================
module score_display
    import score_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 32
) (
    input  logic                    Clock,
    input  logic                    reset,
    input  logic [VALUE_W-1:0]      score,
    input  logic [VALUE_W-1:0]      highScore,
    input  logic                    showHigh,
    output logic                    busy,
    output logic                    valid,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [6:0]              HEX0,
    output logic [6:0]              HEX1,
    output logic [6:0]              HEX2,
    output logic [6:0]              HEX3,
    output logic [6:0]              HEX4,
    output logic [6:0]              HEX5
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W);

    localparam logic [BCD_W-1:0]   c_BCD_SAT = {NUM_DIGITS{4'h9}};
    localparam logic [CNT_W-1:0]   c_CNT_TOP = CNT_W'(VALUE_W - 1);
    localparam logic [VALUE_W-1:0] c_MAX_VAL = VALUE_W'(BCD_MAX);

`ifdef SCORE_DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] c_SEG_UPPER_RST = SEG_BLANK;
`else
    localparam logic [6:0] c_SEG_UPPER_RST = SEG_ZERO;
`endif

    state_t               r_state;
    logic [VALUE_W-1:0]   r_last_value;
    logic                 r_last_sel;
    logic [VALUE_W-1:0]   r_bin;
    logic [BCD_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_over;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_overflow;
    logic [BCD_W-1:0]     r_bcd;
    logic [6:0]           r_hex [NUM_DIGITS];

    logic [VALUE_W-1:0]       w_sel;
    logic                     w_start;
    logic [BCD_W-1:0]         w_acc_adj;
    logic [BCD_W+VALUE_W-1:0] w_shift;
    logic [BCD_W-1:0]         w_bcd_next;
    logic [NUM_DIGITS-1:0]    w_blank;
    logic [6:0]               w_seg [NUM_DIGITS];

    assign w_sel   = showHigh ? highScore : score;
    assign w_start = (w_sel != r_last_value) || (showHigh != r_last_sel);

    // Add-3 correction on every digit >= 5 before the shift
    always_comb begin
        w_acc_adj = r_acc;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_acc[4*k +: 4] >= 4'd5) begin
                w_acc_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
            end
        end
    end

    // Joint left shift of {accumulator, binary}; the carry out of the top
    // digit falls off the end, saturation already accounts for it
    assign w_shift    = {w_acc_adj, r_bin} << 1;
    assign w_bcd_next = r_over ? c_BCD_SAT : r_acc;

`ifdef SCORE_DISPLAY_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every digit above it are zero
    always_comb begin
        w_blank = '0;
        w_blank[NUM_DIGITS-1] = (w_bcd_next[4*(NUM_DIGITS-1) +: 4] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
            w_blank[k] = w_blank[k+1] && (w_bcd_next[4*k +: 4] == 4'd0);
        end
    end
`else
    assign w_blank = '0;
`endif

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
            seg7_decoder u_dec (
                .i_digit (w_bcd_next[4*k +: 4]),
                .i_blank (w_blank[k]),
                .o_seg   (w_seg[k])
            );
        end
    endgenerate

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_value <= '0;
            r_last_sel   <= 1'b0;
            r_bin        <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_over       <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_overflow   <= 1'b0;
            r_bcd        <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_hex[k] <= (k == 0) ? SEG_ZERO : c_SEG_UPPER_RST;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_last_value <= w_sel;
                        r_last_sel   <= showHigh;
                        r_bin        <= w_sel;
                        r_acc        <= '0;
                        r_over       <= (w_sel > c_MAX_VAL);
                        r_cnt        <= c_CNT_TOP;
                        r_busy       <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc <= w_shift[BCD_W+VALUE_W-1 -: BCD_W];
                    r_bin <= w_shift[VALUE_W-1:0];
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    r_bcd      <= w_bcd_next;
                    r_overflow <= r_over;
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        r_hex[k] <= w_seg[k];
                    end
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign overflow = r_overflow;
    assign bcd      = r_bcd;
    assign HEX0     = r_hex[0];
    assign HEX1     = r_hex[1];
    assign HEX2     = r_hex[2];
    assign HEX3     = r_hex[3];
    assign HEX4     = r_hex[4];
    assign HEX5     = r_hex[5];

endmodule : score_display
`default_nettype wire
